// File: rtl/if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// if_prefetch_pkg
// Shared definitions for the instruction-fetch prefetch unit.
//   fetch_state_e      : request tracking FSM states
//                          RUN  - nothing outstanding, a new request may issue
//                          WAIT - one request outstanding, its response is kept
//                          DROP - one request outstanding, its response is stale
//   DEFAULT_RESET_PC   : default first fetch address after reset
//   DEFAULT_EXC_VECTOR : default fetch address taken on an exception
// ----------------------------------------------------------------------------
package if_prefetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/if_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {address, instruction} entries for the
// prefetch unit. The head entry is presented combinationally on rd_data.
// Ports:
//   clk      : clock
//   srst     : synchronous active-high reset (empties the FIFO)
//   clr      : synchronous clear, same effect as srst (used on redirects)
//   push     : write wr_data at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wr_data  : entry to write
//   rd_data  : head entry (meaningless when empty)
//   count    : occupancy, 0..DEPTH
//   empty    : count == 0
//   full     : count == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] wr_en;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // One-hot write enable per entry
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end

    // Storage is not reset; only pointers/count carry state that matters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch
// Instruction prefetch unit: issues single-outstanding fetch requests to the
// instruction memory and queues the returned instructions for decode.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   hold_pc      : stop issuing new requests (outstanding one still completes)
//   br/pc_branch : branch redirect strobe and target
//   except       : exception redirect strobe (wins over br), target EXC_VECTOR
//   imem_req     : one-cycle request pulse, imem_addr valid with it (else 0)
//   imem_ack     : response strobe, imem_rdata valid with it
//   hold_if      : decode stall, head entry is not consumed
//   inst_valid   : queue head valid; inst_out/pc_out head instruction/address
//   q_count      : queue occupancy
// ----------------------------------------------------------------------------
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold_pc,
    input  logic                       br,
    input  logic [ADDR_W-1:0]          pc_branch,
    input  logic                       except,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       hold_if,
    output logic                       inst_valid,
    output logic [DATA_W-1:0]          inst_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] req_addr_reg, req_addr_next;   // address of the outstanding request
    logic [ADDR_W-1:0] last_pc_reg;
    logic [DATA_W-1:0] last_inst_reg;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              fifo_full;

    assign redirect    = br || except;
    // Targets are word aligned: the two low bits are dropped.
    assign redirect_pc = (except ? EXC_VECTOR : pc_branch) & ~ADDR_W'(3);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        issue         = 1'b0;
        push          = 1'b0;
        pop           = !fifo_empty && !hold_if && !redirect;

        case (state_reg)
            RUN: begin
                // Nothing is outstanding here, so queue space alone decides
                // whether the response of a new request is guaranteed a slot.
                // An imem_ack seen in this state belongs to nothing: ignored.
                if (!redirect && !hold_pc && !fifo_full) begin
                    issue         = 1'b1;
                    req_addr_next = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                // A response coinciding with a redirect belongs to the old path.
                push = imem_ack && !redirect;
                if (imem_ack) begin
                    state_next = RUN;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (redirect) begin
            fetch_pc_next = redirect_pc;
        end

        if (rst) begin
            issue = 1'b0;
            push  = 1'b0;
            pop   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            fetch_pc_reg  <= RESET_PC;
            req_addr_reg  <= '0;
            last_pc_reg   <= '0;
            last_inst_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            req_addr_reg  <= req_addr_next;
            // Remember whatever is shown so the outputs hold once the queue empties.
            last_pc_reg   <= pc_out;
            last_inst_reg <= inst_out;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (rst),
        .clr     (redirect),
        .push    (push),
        .pop     (pop),
        .wr_data ({req_addr_reg, imem_rdata}),
        .rd_data (head),
        .count   (count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign imem_req   = issue;
    assign imem_addr  = issue ? fetch_pc_reg : '0;
    assign inst_valid = !fifo_empty;
    assign inst_out   = fifo_empty ? last_inst_reg : head[DATA_W-1:0];
    assign pc_out     = fifo_empty ? last_pc_reg : head[ENT_W-1:DATA_W];
    assign q_count    = count;

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32: PC/address width.
- DATA_W, 32: instruction width.
- DEPTH, 4: prefetch queue entries, power of two, >=2.
- RESET_PC, 0x00000000: first fetch address after reset.
- EXC_VECTOR, 0x00000080: fetch address on exception.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold_pc  in  1  stop issuing new fetch requests.
- br  in  1  branch redirect strobe.
- pc_branch  in  ADDR_W  branch target.
- except  in  1  exception redirect strobe.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  ADDR_W  request address, valid with imem_req.
- imem_ack  in  1  response strobe, at least 1 cycle after imem_req.
- imem_rdata  in  DATA_W  instruction, valid with imem_ack.
- hold_if  in  1  decode stall; head not consumed.
- inst_valid  out  1  queue head valid.
- inst_out  out  DATA_W  head instruction.
- pc_out  out  ADDR_W  head instruction address.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-003 Single outstanding memory request; imem_req SHALL NOT pulse while a request is outstanding.
REQ-004 Issue SHALL occur when state RUN, !hold_pc, no redirect this cycle, and q_count + outstanding < DEPTH; fetch_pc then advances by 4, modulo 2^ADDR_W.
REQ-005 FSM states: RUN (may issue), WAIT (request outstanding), DROP (outstanding response to discard).
REQ-006 Transitions: RUN->WAIT on issue; WAIT->RUN on imem_ack; WAIT->DROP on redirect without ack; DROP->RUN on imem_ack; redirect in DROP stays DROP.
REQ-007 In WAIT, imem_ack SHALL push {imem_rdata, request address} into the queue; visible on outputs the following cycle.
REQ-008 In DROP, or when imem_ack coincides with a redirect, the response SHALL be discarded.
REQ-009 Pop occurs when inst_valid && !hold_if; simultaneous push and pop SHALL leave q_count unchanged.
REQ-010 Redirect: except has priority over br; target is EXC_VECTOR or pc_branch with bits[1:0] forced to 0; queue cleared same edge; fetch_pc loaded; no issue on the redirect cycle.
REQ-011 Redirect overrides a coincident pop; queue empty next cycle.
REQ-012 inst_valid = (q_count != 0); inst_out/pc_out hold the last value when empty.
REQ-013 Queue SHALL never overflow or underflow; REQ-004 reservation guarantees space for every accepted response.
REQ-014 hold_pc SHALL NOT cancel an outstanding request; its response is still queued.

Reset
REQ-015 rst SHALL override all inputs; next cycle: state RUN, fetch_pc=RESET_PC, queue empty, q_count=0, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, pc_out=0.
REQ-016 rst mid-request SHALL abandon the outstanding request; an imem_ack arriving in RUN with nothing outstanding SHALL be ignored.
REQ-017 First imem_req SHALL occur on the first cycle after rst deasserts, with imem_addr=RESET_PC.

Structure
REQ-018 Shared package holds the FSM state enum (RUN, WAIT, DROP) and the EXC_VECTOR/RESET_PC defaults.
REQ-019 Queue SHALL be a sub-module fetch_fifo (parametrised width ADDR_W+DATA_W, depth DEPTH, synchronous clear).

Verification
REQ-020 Reset, 1-cycle memory, hold_if=0 -> imem_addr 0,4,8,...; inst_valid first high 2 cycles after first req; pc_out increments by 4.
REQ-021 hold_if=1 for 10 cycles, DEPTH=4 -> q_count saturates at 4, exactly 4 requests issued; release -> in-order drain, no loss.
REQ-022 br with pc_branch=0x103 during WAIT, 3-cycle latency -> DROP; stale response discarded; next req address 0x100; queue empty after redirect.
REQ-023 except and br same cycle -> next req address 0x80; br ignored.
REQ-024 imem_ack coincident with br -> response not queued; q_count=0 next cycle; next req at pc_branch.
REQ-025 fetch_pc=0xFFFFFFFC, ADDR_W=32 -> next request address 0x00000000.
